// File: rtl/fast_protocol_pkg.sv
// Shared constants and width helpers for the fast_protocol multiplier pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fast_protocol_pkg;

  // Legal pipeline depth: operand stage plus result stage is the minimum.
  localparam int NUM_STAGE_MIN = 2;
  localparam int NUM_STAGE_MAX = 8;

  // Ceiling log2, for sizing counters/indices from a depth.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max_f(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Width of the stored product. When an operand is unsigned, the product
  // keeps one extra bit so it can always be carried as a two's complement value.
  function automatic int prod_width(input int w0, input int w1, input bit s0, input bit s1);
    return w0 + w1 + ((s0 && s1) ? 0 : 1);
  endfunction

endpackage

// File: rtl/fast_protocol_round_sat.sv
// Round / arithmetic-shift / clamp-or-wrap of a signed product, with overflow flag.
// Latency: 0 (purely combinational; the caller registers the result).
// Backpressure: none (no handshake, evaluated every cycle).
// Ports: prod_i  signed product (PW bits)
//        dout_o  scaled result (DW bits, signed iff OUT_SIGNED)
//        ovf_o   result was clamped (SATURATE=1) or wrapped (SATURATE=0)
module fast_protocol_round_sat
  import fast_protocol_pkg::*;
#(
  parameter int PW         = 26,
  parameter int DW         = 16,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 1,
  parameter int OUT_SIGNED = 1
) (
  input  logic signed [PW-1:0] prod_i,
  output logic [DW-1:0]        dout_o,
  output logic                 ovf_o
);

  // One bit of headroom so the rounding increment can never overflow.
  localparam int RW = PW + 1;
  // Compare width: holds R and the unsigned max of the output range as signed values.
  localparam int CW = max_f(RW, DW) + 1;

  localparam logic signed [RW-1:0] RND_INC =
    (ROUND != 0 && SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  localparam logic signed [CW-1:0] ONE   = CW'(1);
  localparam logic signed [CW-1:0] MAX_C =
    (OUT_SIGNED != 0) ? ((ONE <<< (DW - 1)) - ONE) : ((ONE <<< DW) - ONE);
  localparam logic signed [CW-1:0] MIN_C =
    (OUT_SIGNED != 0) ? -(ONE <<< (DW - 1)) : '0;

  logic signed [RW-1:0] sum;
  logic signed [RW-1:0] r;
  logic signed [CW-1:0] r_c;
  logic [DW-1:0]        low;
  logic [CW-1:0]        wrap_c;

  assign sum    = $signed({prod_i[PW-1], prod_i}) + RND_INC;
  assign r      = sum >>> SHIFT;
  assign r_c    = {{(CW - RW){r[RW-1]}}, r};
  assign low    = r_c[DW-1:0];
  // Re-extend the kept bits the way a consumer would read them; any
  // difference from R means information was lost by wrapping.
  assign wrap_c = {{(CW - DW){(OUT_SIGNED != 0) ? low[DW-1] : 1'b0}}, low};

  always_comb begin
    dout_o = low;
    ovf_o  = 1'b0;
    if (SATURATE != 0) begin
      if (r_c > MAX_C) begin
        dout_o = MAX_C[DW-1:0];
        ovf_o  = 1'b1;
      end else if (r_c < MIN_C) begin
        dout_o = MIN_C[DW-1:0];
        ovf_o  = 1'b1;
      end
    end else begin
      ovf_o = (wrap_c != r_c);
    end
  end

endmodule

// File: rtl/fast_protocol_mul_pipe.sv
// Elastic pipelined fixed-point multiplier (price x qty / scaling) with round, shift, saturate.
// Latency: NUM_STAGE cycles from accept to out_valid when not stalled; 1 result/cycle sustained.
// Backpressure: valid/ready on both sides; stalls ripple back only through full stages, bubbles collapse.
// Ports: ap_clk/ap_rst_n          clock, async active-low reset
//        in_valid/in_ready/din0/din1  operand handshake
//        out_valid/out_ready/dout/ovf result handshake (ovf qualified by out_valid)
module fast_protocol_mul_pipe
  import fast_protocol_pkg::*;
#(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 9,
  parameter int DOUT_WIDTH  = 16,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 3,
  parameter int SHIFT       = 0,
  parameter int ROUND       = 0,
  parameter int SATURATE    = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int N          = NUM_STAGE;
  localparam int OUT_SIGNED = (DIN0_SIGNED != 0 || DIN1_SIGNED != 0) ? 1 : 0;
  localparam int PW         = prod_width(DIN0_WIDTH, DIN1_WIDTH, DIN0_SIGNED != 0, DIN1_SIGNED != 0);

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_num_stage
    $error("fast_protocol_mul_pipe: NUM_STAGE out of range");
  end

  logic [N:1] v_q, v_d;
  logic [N:1] ld;          // stage i captures this cycle (empty or draining downstream)

  logic signed [DIN0_WIDTH:0] a_q;
  logic signed [DIN1_WIDTH:0] b_q;
  logic signed [PW-1:0]       a_w, b_w, prod_p, p_last;
  logic [DOUT_WIDTH-1:0]      rs_dout, dout_q;
  logic                       rs_ovf, ovf_q;

  // Ready chain from the output back to the input: a stage can take new
  // data if it is empty or its occupant moves on this cycle.
  always_comb begin
    ld    = '0;
    ld[N] = !v_q[N] || out_ready;
    for (int i = N - 1; i >= 1; i--) begin
      ld[i] = !v_q[i] || ld[i+1];
    end
    v_d = v_q;
    if (ld[1]) v_d[1] = in_valid;
    for (int i = 2; i <= N; i++) begin
      if (ld[i]) v_d[i] = v_q[i-1];
    end
  end

  // Operands carry an explicit extension bit (zero for unsigned) so one
  // signed multiply covers every signedness combination.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      v_q <= v_d;
      if (ld[1] && in_valid) begin
        a_q <= {(DIN0_SIGNED != 0) ? din0[DIN0_WIDTH-1] : 1'b0, din0};
        b_q <= {(DIN1_SIGNED != 0) ? din1[DIN1_WIDTH-1] : 1'b0, din1};
      end
      if (ld[N] && v_q[N-1]) begin
        dout_q <= rs_dout;
        ovf_q  <= rs_ovf;
      end
    end
  end

  assign a_w    = PW'(a_q);
  assign b_w    = PW'(b_q);
  assign prod_p = a_w * b_w;

  if (N > 2) begin : g_mid
    logic signed [PW-1:0] p_q [N-2];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int k = 0; k < N - 2; k++) p_q[k] <= '0;
      end else begin
        if (ld[2] && v_q[1]) p_q[0] <= prod_p;
        for (int k = 1; k < N - 2; k++) begin
          if (ld[k+2] && v_q[k+1]) p_q[k] <= p_q[k-1];
        end
      end
    end

    assign p_last = p_q[N-3];
  end else begin : g_direct
    assign p_last = prod_p;
  end

  fast_protocol_round_sat #(
    .PW         (PW),
    .DW         (DOUT_WIDTH),
    .SHIFT      (SHIFT),
    .ROUND      (ROUND),
    .SATURATE   (SATURATE),
    .OUT_SIGNED (OUT_SIGNED)
  ) u_round_sat (
    .prod_i (p_last),
    .dout_o (rs_dout),
    .ovf_o  (rs_ovf)
  );

  assign in_ready  = ld[1];
  assign out_valid = v_q[N];
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fast_protocol_mul_pipe.sv
// Bench for fast_protocol_mul_pipe: four instances (saturate, wrap, shift+round, shift truncate)
// share one operand/handshake stream; each is checked against an arithmetic reference model.
module tb_fast_protocol_mul_pipe;

  typedef struct {
    int cfg;
    int a;
    int b;
    int d;
    bit o;
  } vec_t;

  typedef struct {
    int a;
    int b;
    int t;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] din0;
  logic [8:0]  din1;
  logic        ir_w   [4];
  logic        ov_w   [4];
  logic [15:0] dout_w [4];
  logic        ovf_w  [4];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_acc = 0;
  bit          held = 1'b0;
  logic [15:0] held_d;
  logic        held_o;
  bit          chk_lat = 1'b0;
  sb_t         sb [$];

  always #5 clk = ~clk;

  // cfg0: defaults; cfg1: wrap; cfg2: SHIFT=8 round; cfg3: SHIFT=8 truncate.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    fast_protocol_mul_pipe #(
      .SHIFT    ((g >= 2) ? 8 : 0),
      .ROUND    ((g == 2) ? 1 : 0),
      .SATURATE ((g == 1) ? 0 : 1)
    ) u_dut (
      .ap_clk    (clk),
      .ap_rst_n  (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir_w[g]),
      .din0      (din0),
      .din1      (din1),
      .out_valid (ov_w[g]),
      .out_ready (out_ready),
      .dout      (dout_w[g]),
      .ovf       (ovf_w[g])
    );
  end

  task automatic check_eq(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer product, half-up rounding, floor shift, then clamp or wrap.
  function automatic void ref_model(input int cfg, input int a, input int b, output int d, output bit o);
    longint p, r;
    int sh;
    sh = (cfg >= 2) ? 8 : 0;
    p  = longint'(a) * longint'(b);
    if (cfg == 2) p = p + (longint'(1) << (sh - 1));
    r = p >>> sh;
    if (cfg != 1) begin
      if (r > 32767) begin
        d = 32767; o = 1'b1;
      end else if (r < -32768) begin
        d = -32768; o = 1'b1;
      end else begin
        d = int'(r); o = 1'b0;
      end
    end else begin
      d = int'(r & 64'hFFFF);
      if (d >= 32768) d = d - 65536;
      o = (longint'(d) != r);
    end
  endfunction

  // One clock of stimulus plus scoreboard/handshake checks, evaluated just after the negedge.
  task automatic cycle(input bit iv, input int a, input int b, input bit ordy);
    sb_t e;
    int  ed;
    bit  eo;
    @(negedge clk);
    in_valid  = iv;
    din0      = a[15:0];
    din1      = b[8:0];
    out_ready = ordy;
    #1;
    if (held) check_eq("hold_stable", {ov_w[0], ovf_w[0], dout_w[0]}, {1'b1, held_o, held_d});
    check_eq("in_ready", ir_w[0], (sb.size() == 3 && !ordy) ? 1'b0 : 1'b1);
    if (ov_w[0] && ordy) begin
      check_eq("out_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (chk_lat) check_eq("latency", cyc - e.t, 3);
        for (int c = 0; c < 4; c++) begin
          ref_model(c, e.a, e.b, ed, eo);
          check_eq($sformatf("dout_cfg%0d a=%0d b=%0d", c, e.a, e.b), $signed(dout_w[c]), ed);
          check_eq($sformatf("ovf_cfg%0d a=%0d b=%0d", c, e.a, e.b), ovf_w[c], eo);
        end
      end
    end
    held   = ov_w[0] && !ordy;
    held_d = dout_w[0];
    held_o = ovf_w[0];
    if (iv && ir_w[0]) begin
      sb.push_back('{a, b, cyc});
      n_acc++;
    end
    cyc++;
  endtask

  initial begin
    vec_t        vecs [19];
    int          lat;
    int          ta, tb;
    int          ra, rb;
    int          seen;
    logic [15:0] r16;

    vecs[0]  = '{0, 100, 200, 20000, 1'b0};
    vecs[1]  = '{0, -32768, 511, -32768, 1'b1};
    vecs[2]  = '{0, 300, 200, 32767, 1'b1};
    vecs[3]  = '{0, 32767, 1, 32767, 1'b0};
    vecs[4]  = '{0, -32768, 0, 0, 1'b0};
    vecs[5]  = '{0, -64, 511, -32704, 1'b0};
    vecs[6]  = '{0, -65, 511, -32768, 1'b1};
    vecs[7]  = '{0, 128, 256, 32767, 1'b1};
    vecs[8]  = '{1, 300, 200, -5536, 1'b1};
    vecs[9]  = '{1, -5, 7, -35, 1'b0};
    vecs[10] = '{1, -32768, 511, -32768, 1'b1};
    vecs[11] = '{1, 128, 256, -32768, 1'b1};
    vecs[12] = '{2, 384, 1, 2, 1'b0};
    vecs[13] = '{2, -384, 1, -1, 1'b0};
    vecs[14] = '{2, 127, 1, 0, 1'b0};
    vecs[15] = '{2, 128, 1, 1, 1'b0};
    vecs[16] = '{2, -129, 1, -1, 1'b0};
    vecs[17] = '{3, 384, 1, 1, 1'b0};
    vecs[18] = '{3, -1, 1, -1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din0 = '0; din1 = '0;
    #1;
    for (int c = 0; c < 4; c++) check_eq($sformatf("rst_out_valid%0d", c), ov_w[c], 0);
    check_eq("rst_dout", dout_w[0], 0);
    check_eq("rst_ovf", ovf_w[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) check_eq($sformatf("post_rst_in_ready%0d", c), ir_w[c], 1);

    // Directed vectors: one operand pair at a time through an empty pipeline.
    foreach (vecs[i]) begin
      @(negedge clk);
      ta = vecs[i].a; tb = vecs[i].b;
      in_valid = 1'b1; din0 = ta[15:0]; din1 = tb[8:0]; out_ready = 1'b1;
      #1;
      check_eq("vec_in_ready", ir_w[0], 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!ov_w[vecs[i].cfg] && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check_eq($sformatf("vec%0d_latency", i), lat, 3);
      check_eq($sformatf("vec%0d_dout", i), $signed(dout_w[vecs[i].cfg]), vecs[i].d);
      check_eq($sformatf("vec%0d_ovf", i), ovf_w[vecs[i].cfg], vecs[i].o);
    end

    // Random operands with random in_valid / out_ready.
    n_acc = 0;
    for (int k = 0; k < 3000 && n_acc < 64; k++) begin
      r16 = 16'($urandom);
      ra  = ($urandom_range(0, 1) == 1) ? int'($signed(r16)) : int'($urandom_range(0, 400)) - 200;
      rb  = int'($urandom_range(0, 511));
      cycle(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
    end
    check_eq("rand_accepts", n_acc, 64);
    for (int k = 0; k < 40 && sb.size() > 0; k++) cycle(1'b0, 0, 0, 1'b1);
    check_eq("rand_drain", sb.size(), 0);

    // Back-to-back stream with no stalls: 1/cycle, fixed latency.
    chk_lat = 1'b1;
    n_acc   = 0;
    for (int k = 0; k < 8; k++) cycle(1'b1, int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 511)), 1'b1);
    check_eq("stream_accepts", n_acc, 8);
    for (int k = 0; k < 6; k++) cycle(1'b0, 0, 0, 1'b1);
    check_eq("stream_drain", sb.size(), 0);
    chk_lat = 1'b0;

    // Reset with three results in flight.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1000 + k, 5, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("flight_before_rst", ov_w[0], 1);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) check_eq($sformatf("midrst_out_valid%0d", c), ov_w[c], 0);
    check_eq("midrst_dout", dout_w[0], 0);
    sb.delete();
    held = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rerst_in_ready", ir_w[0], 1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (ov_w[0]) seen++;
    end
    check_eq("no_emit_after_rst", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
